maze_walker: RTL and testbench
==============================

# maze_walker

Parametrised wall-follower engine that walks a rectangular maze stored in an external synchronous single-bit memory. It reads cells through `row`/`col`/`maze_oe` and marks visited cells through `maze_we`, as earlier maze blocks do. Over those blocks it adds:
- configurable maze dimensions;
- selectable right-hand or left-hand rule;
- a start handshake;
- a boxed-in failure exit;
- a step counter, with an optional step-limit abort.

## Interface
- `ROW_W`, 6: row index width.
- `COL_W`, 6: column index width.
- `MAZE_ROWS`, 64: number of rows; the last row index is `MAZE_ROWS-1`. Must be ≤ 2^ROW_W.
- `MAZE_COLS`, 64: number of columns. Must be ≤ 2^COL_W.
- `STEP_W`, 16: width of `step_count`.
- `STEP_LIMIT`, 16'hFFFF: abort threshold. Used only with `MAZE_WALKER_STEP_LIMIT_EN`.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: begin a walk. Sampled in IDLE, DONE or FAIL.
- `hand_sel` input, 1 bit: 0 = right-hand rule, 1 = left-hand rule. Latched with `start`.
- `starting_row` input, ROW_W bits: start cell row. Latched with `start`.
- `starting_col` input, COL_W bits: start cell column. Latched with `start`.
- `maze_in` input, 1 bit: cell content; 1 = wall, 0 = free. Valid in the cycle after `maze_oe`.
- `row` output, ROW_W bits: registered cell select.
- `col` output, COL_W bits: registered cell select.
- `maze_oe` output, 1 bit: registered read strobe.
- `maze_we` output, 1 bit: registered visit-mark strobe.
- `busy` output, 1 bit: walk in progress.
- `done` output, 1 bit: exit reached. Sticky.
- `fail` output, 1 bit: boxed in or step limit hit. Sticky.
- `step_count` output, STEP_W bits: number of successful moves in the current walk.

## Operation
- Heading encoding: N=0, E=1, S=2, W=3 (clockwise). Arithmetic is modulo 4.
- Neighbour offsets: N = row-1, S = row+1, W = col-1, E = col+1.
- Candidate order for try index t=0..3, relative to heading h:
  - right-hand: h+1, h, h+3, h+2;
  - left-hand: h+3, h, h+1, h+2.
- Initial heading is N.
- States:
  - IDLE: on `start`, latch start cell and `hand_sel`, clear `step_count`/`done`/`fail`, set h=N, go to MARK.
  - MARK: drive `row`/`col` = current cell and `maze_we`=1.
    - If the current cell is on the boundary (row==0, row==MAZE_ROWS-1, col==0 or col==MAZE_COLS-1), go to DONE.
    - Otherwise set t=0 and go to PROBE.
  - PROBE: drive `row`/`col` = candidate(t) and `maze_oe`=1. Go to WAIT.
  - WAIT: `maze_oe`=0; sample `maze_in` at the end of the cycle.
    - Free (0): current cell ← candidate, h ← candidate direction, `step_count`+1, go to MARK.
    - Wall (1) and t<3: t+1, go to PROBE.
    - Wall (1) and t==3: go to FAIL.
  - DONE: `done`=1, `busy`=0. A new `start` restarts the walk as from IDLE.
  - FAIL: `fail`=1, `busy`=0. A new `start` restarts the walk as from IDLE.
- `start` is ignored while `busy`=1.
- A candidate is never outside the maze: the boundary check in MARK ends the walk before any edge cell is expanded.
- If the start cell is on the boundary: MARK, then DONE, with `step_count`=0.
- `step_count` saturates at all-ones and never wraps.

## Timing
- Reset (`rst_n`=0 at a rising edge) produces on the next cycle: state IDLE; `row`=0, `col`=0, `maze_oe`=0, `maze_we`=0, `busy`=0, `done`=0, `fail`=0, `step_count`=0.
- Reset mid-walk aborts immediately. No further strobes are issued.
- The `start` edge moves the block to MARK; `busy`=1 from the following cycle.
- Memory contract: `maze_oe` is registered and high for exactly one cycle (PROBE). `maze_in` is valid in the next cycle (WAIT).
- A move whose first try succeeds costs 3 cycles (MARK, PROBE, WAIT). Each extra failed try adds 2 cycles.
- `maze_oe` and `maze_we` are never high in the same cycle.
- `done` or `fail` rises one cycle after the final MARK (boundary exit) or the final WAIT (failure).

## Configuration
- `MAZE_WALKER_STEP_LIMIT_EN` defined:
  - In WAIT, a free result that would make `step_count` equal `STEP_LIMIT` completes the move (mark included), then goes to FAIL instead of PROBE.
  - Exception: if the new cell is on the boundary, DONE takes priority.
- Not defined: no limit logic is built; `fail` asserts only when boxed in.

## Test plan
- 8x8 maze (`MAZE_ROWS`=`MAZE_COLS`=8); start (3,3); `hand_sel`=0; only (2,3), (1,3), (0,3) free.
  - Required: probe E, then N at each step; `done`=1; `step_count`=3; last `maze_we` at (0,3).
  - Required: first `maze_oe` exactly 2 cycles after `start` is accepted.
- Same maze with `hand_sel`=1.
  - Required: first probe W (2,... i.e. cell (3,2)), then N; same `done`/`step_count`=3 result.
- Start (4,4) with all four neighbours walls.
  - Required: 4 probes in order E, N, W, S; `fail`=1; `done`=0; `step_count`=0.
- Start on boundary, (0,5).
  - Required: one `maze_we` at (0,5); `done`=1 on the next cycle; no `maze_oe`.
- `rst_n`=0 asserted during a WAIT cycle.
  - Required: next cycle all outputs 0, state IDLE; the following `start` walks correctly.
- With `MAZE_WALKER_STEP_LIMIT_EN` defined and `STEP_LIMIT`=2, on a corridor needing 3 steps.
  - Required: `fail`=1; `step_count`=2; exactly 3 `maze_we` pulses, including the start mark.

Source files
------------

// File: rtl/maze_walker.sv
// maze_walker: wall-follower engine walking a rectangular maze held in an
// external synchronous single-bit memory (1 = wall, 0 = free).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         begin a walk (accepted in IDLE, DONE or FAIL)
//   hand_sel      0 = right-hand rule, 1 = left-hand rule (latched with start)
//   starting_row  start cell row (latched with start)
//   starting_col  start cell column (latched with start)
//   maze_in       cell content, valid the cycle after maze_oe
//   row, col      registered cell select
//   maze_oe       registered read strobe (one cycle, PROBE)
//   maze_we       registered visit-mark strobe (MARK)
//   busy          walk in progress
//   done          exit reached (sticky until next start)
//   fail          boxed in or step limit hit (sticky until next start)
//   step_count    successful moves in the current walk, saturating
//
// Optional feature: define MAZE_WALKER_STEP_LIMIT_EN to abort the walk once
// step_count reaches STEP_LIMIT (reaching the boundary on that move still
// counts as DONE).
module maze_walker #(
  parameter int unsigned ROW_W      = 6,
  parameter int unsigned COL_W      = 6,
  parameter int unsigned MAZE_ROWS  = 64,
  parameter int unsigned MAZE_COLS  = 64,
  parameter int unsigned STEP_W     = 16,
  parameter logic [STEP_W-1:0] STEP_LIMIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hand_sel,
  input  logic [ROW_W-1:0]  starting_row,
  input  logic [COL_W-1:0]  starting_col,
  input  logic              maze_in,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_PROBE, S_WAIT, S_DONE, S_FAIL
  } state_t;

  // Headings, clockwise so that "turn right" is +1 modulo 4.
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAZE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAZE_COLS - 1);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [1:0]         head_q, head_d;
  logic [1:0]         try_q, try_d;
  logic               hand_q, hand_d;
  logic               limit_q, limit_d;
  logic [STEP_W-1:0]  step_d;
  logic [ROW_W-1:0]   row_d;
  logic [COL_W-1:0]   col_d;
  logic               oe_d, we_d;

  // Direction tried at index t relative to heading h.
  function automatic logic [1:0] cand_dir(input logic [1:0] h,
                                          input logic       left,
                                          input logic [1:0] t);
    logic [1:0] off;
    case (t)
      2'd0:    off = left ? 2'd3 : 2'd1;
      2'd1:    off = 2'd0;
      2'd2:    off = left ? 2'd1 : 2'd3;
      default: off = 2'd2;
    endcase
    return h + off;
  endfunction

  logic [1:0]        next_try;    // try index the next probe will use
  logic [1:0]        probe_dir;   // direction of the next probe
  logic [1:0]        move_dir;    // direction of the probe now being answered
  logic [ROW_W-1:0]  probe_row;
  logic [COL_W-1:0]  probe_col;
  logic              on_edge;
  logic [STEP_W-1:0] step_inc;

  assign next_try  = (state_q == S_WAIT) ? try_q + 2'd1 : 2'd0;
  assign probe_dir = cand_dir(head_q, hand_q, next_try);
  assign move_dir  = cand_dir(head_q, hand_q, try_q);
  assign on_edge   = (cur_row_q == '0) || (cur_row_q == LAST_ROW) ||
                     (cur_col_q == '0) || (cur_col_q == LAST_COL);
  assign step_inc  = (&step_count) ? step_count : step_count + STEP_W'(1);

  // Interior cells only are ever expanded, so the +/-1 never wraps.
  always_comb begin
    probe_row = cur_row_q;
    probe_col = cur_col_q;
    case (probe_dir)
      DIR_N:   probe_row = cur_row_q - ROW_W'(1);
      DIR_E:   probe_col = cur_col_q + COL_W'(1);
      DIR_S:   probe_row = cur_row_q + ROW_W'(1);
      default: probe_col = cur_col_q - COL_W'(1);
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    head_d    = head_q;
    try_d     = try_q;
    hand_d    = hand_q;
    limit_d   = limit_q;
    step_d    = step_count;
    row_d     = row;
    col_d     = col;
    oe_d      = 1'b0;
    we_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_row_d = starting_row;
          cur_col_d = starting_col;
          hand_d    = hand_sel;
          head_d    = DIR_N;
          step_d    = '0;
          limit_d   = 1'b0;
          row_d     = starting_row;
          col_d     = starting_col;
          we_d      = 1'b1;
          state_d   = S_MARK;
        end
      end
      S_MARK: begin
        if (on_edge) begin
          state_d = S_DONE;
        end else if (limit_q) begin
          state_d = S_FAIL;
        end else begin
          try_d   = 2'd0;
          row_d   = probe_row;
          col_d   = probe_col;
          oe_d    = 1'b1;
          state_d = S_PROBE;
        end
      end
      S_PROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (!maze_in) begin
          // row/col still hold the probed cell, which becomes current.
          cur_row_d = row;
          cur_col_d = col;
          head_d    = move_dir;
          step_d    = step_inc;
          we_d      = 1'b1;
          state_d   = S_MARK;
`ifdef MAZE_WALKER_STEP_LIMIT_EN
          if (step_inc == STEP_LIMIT) limit_d = 1'b1;
`endif
        end else if (try_q != 2'd3) begin
          try_d   = next_try;
          row_d   = probe_row;
          col_d   = probe_col;
          oe_d    = 1'b1;
          state_d = S_PROBE;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and all state uses
    // non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      head_q     <= DIR_N;
      try_q      <= 2'd0;
      hand_q     <= 1'b0;
      limit_q    <= 1'b0;
      step_count <= '0;
      row        <= '0;
      col        <= '0;
      maze_oe    <= 1'b0;
      maze_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      head_q     <= head_d;
      try_q      <= try_d;
      hand_q     <= hand_d;
      limit_q    <= limit_d;
      step_count <= step_d;
      row        <= row_d;
      col        <= col_d;
      maze_oe    <= oe_d;
      maze_we    <= we_d;
      busy       <= (state_d == S_MARK) || (state_d == S_PROBE) ||
                    (state_d == S_WAIT);
      done       <= (state_d == S_DONE);
      fail       <= (state_d == S_FAIL);
    end
  end

endmodule

// File: tb/tb_maze_walker.sv
// Testbench for maze_walker on an 8x8 maze. A table of walks (start cell,
// hand, expected outcome) is applied in a loop, followed by hand-written
// sequences for probe order and reset during a WAIT cycle. Expected values
// depend on whether MAZE_WALKER_STEP_LIMIT_EN is defined (STEP_LIMIT = 2).
module tb_maze_walker;

  localparam int RW = 6;
  localparam int CW = 6;

`ifdef MAZE_WALKER_STEP_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hand_sel = 1'b0;
  logic [RW-1:0] starting_row = '0;
  logic [CW-1:0] starting_col = '0;
  logic          maze_in = 1'b1;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          maze_oe, maze_we, busy, done, fail;
  logic [15:0]   step_count;

  maze_walker #(
    .ROW_W(RW), .COL_W(CW), .MAZE_ROWS(8), .MAZE_COLS(8),
    .STEP_W(16), .STEP_LIMIT(16'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hand_sel(hand_sel),
    .starting_row(starting_row), .starting_col(starting_col),
    .maze_in(maze_in), .row(row), .col(col), .maze_oe(maze_oe),
    .maze_we(maze_we), .busy(busy), .done(done), .fail(fail),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Maze: everything is wall except these free cells.
  function automatic logic is_wall(input logic [RW-1:0] r, input logic [CW-1:0] c);
    if (c == 3 && r <= 2) return 1'b0;                 // (0..2,3) corridor
    if (r == 5 && c == 6) return 1'b0;
    if (r == 4 && (c == 6 || c == 7)) return 1'b0;
    return 1'b1;
  endfunction

  // Synchronous single-bit memory.
  always @(posedge clk) if (maze_oe) maze_in <= is_wall(row, col);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  sr, sc;
    logic        hand;
    logic        e_done, e_fail;
    int          e_steps, e_oe, e_we;
    logic [5:0]  e_lr, e_lc;   // last marked cell
    logic [5:0]  e_fr, e_fc;   // first probed cell (when e_oe > 0)
  } walk_t;

  logic [5:0] probe_r[$];
  logic [5:0] probe_c[$];

  task automatic run_walk(input walk_t w);
    int n, oe_n, we_n, first_oe_n, last_we_n, end_n, overlap;
    logic busy1, finished;
    logic [5:0] lr, lc, fr, fc;
    probe_r.delete();
    probe_c.delete();
    @(negedge clk);
    starting_row = w.sr;
    starting_col = w.sc;
    hand_sel     = w.hand;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; oe_n = 0; we_n = 0; first_oe_n = -1; last_we_n = -1; end_n = -1;
    overlap = 0; busy1 = 1'b0; finished = 1'b0;
    lr = '0; lc = '0; fr = '0; fc = '0;
    while (n < 300 && !finished) begin
      @(negedge clk);
      n++;
      if (n == 1) busy1 = busy;
      if (maze_oe && maze_we) overlap++;
      if (maze_oe) begin
        oe_n++;
        probe_r.push_back(row);
        probe_c.push_back(col);
        if (first_oe_n < 0) begin
          first_oe_n = n; fr = row; fc = col;
        end
      end
      if (maze_we) begin
        we_n++; last_we_n = n; lr = row; lc = col;
      end
      if (done || fail) begin
        finished = 1'b1; end_n = n;
      end
    end
    check({w.name, " terminated"}, finished, 1);
    check({w.name, " busy after start"}, busy1, 1);
    check({w.name, " done"}, done, w.e_done);
    check({w.name, " fail"}, fail, w.e_fail);
    check({w.name, " busy at end"}, busy, 0);
    check({w.name, " step_count"}, step_count, w.e_steps);
    check({w.name, " oe pulses"}, oe_n, w.e_oe);
    check({w.name, " we pulses"}, we_n, w.e_we);
    check({w.name, " oe/we overlap"}, overlap, 0);
    check({w.name, " last mark row"}, lr, w.e_lr);
    check({w.name, " last mark col"}, lc, w.e_lc);
    if (w.e_oe > 0) begin
      check({w.name, " first probe row"}, fr, w.e_fr);
      check({w.name, " first probe col"}, fc, w.e_fc);
      check({w.name, " first oe cycle"}, first_oe_n, 2);
    end
    if (w.e_done) check({w.name, " done latency"}, end_n, last_we_n + 1);
    @(negedge clk);
    check({w.name, " sticky"}, {done, fail}, {w.e_done, w.e_fail});
  endtask

  walk_t tbl[5];

  initial begin
    // name, sr, sc, hand, done, fail, steps, oe, we, last r/c, first r/c
    tbl[0] = '{"right33", 6'd3, 6'd3, 1'b0, !LIM, LIM, LIM ? 2 : 3, LIM ? 4 : 6,
               LIM ? 3 : 4, LIM ? 6'd1 : 6'd0, 6'd3, 6'd3, 6'd4};
    tbl[1] = '{"left33", 6'd3, 6'd3, 1'b1, !LIM, LIM, LIM ? 2 : 3, LIM ? 4 : 6,
               LIM ? 3 : 4, LIM ? 6'd1 : 6'd0, 6'd3, 6'd3, 6'd2};
    tbl[2] = '{"boxed44", 6'd4, 6'd4, 1'b0, 1'b0, 1'b1, 0, 4, 1,
               6'd4, 6'd4, 6'd4, 6'd5};
    tbl[3] = '{"edge05", 6'd0, 6'd5, 1'b0, 1'b1, 1'b0, 0, 0, 1,
               6'd0, 6'd5, 6'd0, 6'd0};
    tbl[4] = '{"turn55", 6'd5, 6'd5, 1'b0, !LIM, LIM, LIM ? 2 : 3, LIM ? 4 : 5,
               LIM ? 3 : 4, 6'd4, LIM ? 6'd6 : 6'd7, 6'd5, 6'd6};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {row, col, maze_oe, maze_we, busy, done, fail, step_count},
          '0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_walk(tbl[i]);

    // Two-step walk whose last move lands on the boundary: DONE wins even
    // when that move also reaches the step limit.
    begin
      walk_t w;
      w = '{"left23", 6'd2, 6'd3, 1'b1, 1'b1, 1'b0, 2, 4, 3,
            6'd0, 6'd3, 6'd2, 6'd2};
      run_walk(w);
    end

    // Boxed-in probe order: E, N, W, S.
    run_walk(tbl[2]);
    check("boxed probe count", probe_r.size(), 4);
    if (probe_r.size() == 4) begin
      check("boxed probe0", {probe_r[0], probe_c[0]}, {6'd4, 6'd5});
      check("boxed probe1", {probe_r[1], probe_c[1]}, {6'd3, 6'd4});
      check("boxed probe2", {probe_r[2], probe_c[2]}, {6'd4, 6'd3});
      check("boxed probe3", {probe_r[3], probe_c[3]}, {6'd5, 6'd4});
    end

    // Reset asserted during a WAIT cycle.
    begin
      int k;
      @(negedge clk);
      starting_row = 6'd3; starting_col = 6'd3; hand_sel = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!maze_oe && k < 20);
      check("reset test probe seen", maze_oe, 1);
      @(negedge clk);                 // WAIT cycle
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-walk reset outputs",
            {row, col, maze_oe, maze_we, busy, done, fail, step_count}, '0);
      rst_n = 1'b1;
      k = 0;
      repeat (5) begin
        @(negedge clk);
        if (maze_oe || maze_we || busy) k++;
      end
      check("no strobes after reset", k, 0);
    end
    run_walk(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
